// File: rtl/way4_arb_ctrl.sv
// way4_arb_ctrl: 4-way round-robin arbiter with a registered one-deep output stage.
// Latency: 1 cycle from a request to out_valid. Supports back-to-back transfers at one per cycle.
// Backpressure: a held grant stays frozen while out_ready is low. Optional grant_cnt port under WAY4_ARB_CNT_EN.
module way4_arb_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef WAY4_ARB_CNT_EN
  ,
  output logic [7:0]       grant_cnt
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel;
  logic [3:0]       r_gnt;
  logic [3:0]       w_gnt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out;
  logic             r_vld;
  logic             w_vld;

  // Arbitration helpers
  logic [1:0]       w_base;
  logic [1:0]       w_win;
  logic             w_found;
  logic [WIDTH-1:0] w_win_dat;
  logic             w_hs;

  assign w_hs = r_vld & out_ready;

  // On a handshake the search starts after the channel just delivered,
  // which is the value ptr is about to take; otherwise use the stored ptr.
  assign w_base = (r_state == S_HOLD) ? r_sel : r_ptr;

  // Round-robin search: base+1, base+2, base+3, base; first set request wins.
  always_comb begin : rr_search
    logic [1:0] idx;
    w_win   = 2'd0;
    w_found = 1'b0;
    idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = w_base + 2'(i);
      if (!w_found && req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  // Data mux for the winning channel.
  always_comb begin
    w_win_dat = A;
    case (w_win)
      2'd0: w_win_dat = A;
      2'd1: w_win_dat = B;
      2'd2: w_win_dat = C;
      2'd3: w_win_dat = D;
      default: w_win_dat = A;
    endcase
  end

  // Next-state and next-output logic; everything holds unless a grant is loaded or released.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_sel   = r_sel;
    w_gnt   = r_gnt;
    w_out   = r_out;
    w_vld   = r_vld;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state = S_HOLD;
          w_sel   = w_win;
          w_gnt   = 4'b0001 << w_win;
          w_out   = w_win_dat;
          w_vld   = 1'b1;
        end
      end
      S_HOLD: begin
        // Without out_ready the captured transfer is frozen, regardless of req or data.
        if (out_ready) begin
          w_ptr = r_sel;
          if (w_found) begin
            w_sel = w_win;
            w_gnt = 4'b0001 << w_win;
            w_out = w_win_dat;
            w_vld = 1'b1;
          end else begin
            // sel and out keep their last values while idle.
            w_state = S_IDLE;
            w_gnt   = 4'b0000;
            w_vld   = 1'b0;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_gnt   = 4'b0000;
        w_vld   = 1'b0;
      end
    endcase
  end

  // State and output registers; ptr resets to 3 so the first search begins at A.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd3;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_out   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_sel   <= w_sel;
      r_gnt   <= w_gnt;
      r_out   <= w_out;
      r_vld   <= w_vld;
    end
  end

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out       = r_out;
  assign out_valid = r_vld;

`ifdef WAY4_ARB_CNT_EN
  logic [7:0] r_cnt;

  // Count completed handshakes, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_hs && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign grant_cnt = r_cnt;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_hs;
`endif

endmodule

// File: doc/way4_arb_ctrl.md
WAY4_ARB_CTRL -- requirements
Module: way4_arb_ctrl

Interface
REQ-001 Parameter: WIDTH, default 5, data width of each channel and of the output.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-channel request; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-005 Port: A, B, C, D  input  WIDTH each  channel data, valid while the matching req bit is high.
REQ-006 Port: out_ready  input  1  downstream accepts out when high together with out_valid.
REQ-007 Port: sel  output  2  registered channel index of the current grant, A:00, B:01, C:10, D:11.
REQ-008 Port: gnt  output  4  registered one-hot grant; all zero when no grant is held.
REQ-009 Port: out  output  WIDTH  registered data of the granted channel.
REQ-010 Port: out_valid  output  1  out, sel and gnt hold a transfer.
REQ-011 The block has one clock; reset is synchronous and active-high.

Function
REQ-012 States: IDLE (no grant held, out_valid=0) and HOLD (grant held, out_valid=1).
REQ-013 Arbitration is round-robin: search order starts at ptr+1 and wraps mod 4 (ptr+1, ptr+2, ptr+3, ptr); the first set req bit wins.
REQ-014 IDLE with req!=0: on the next edge, sel=winner, gnt=1<<winner, out=winner's data sampled that cycle, out_valid=1, state goes to HOLD; latency 1 cycle.
REQ-015 IDLE with req==0: all outputs keep their values, out_valid stays 0, gnt stays 0.
REQ-016 HOLD with out_ready=0: sel, gnt and out remain stable; changes on A-D or req have no effect.
REQ-017 HOLD with out_ready=1 (handshake): ptr<=sel; if req!=0 that cycle, a new winner is chosen using the updated ptr and loaded as in REQ-014, staying in HOLD (back-to-back, 1 transfer/cycle); else state goes to IDLE, out_valid=0, gnt=0.
REQ-018 Deasserting the granted req bit during HOLD does not revoke the grant; the captured data is still delivered.
REQ-019 ptr updates only on a handshake, never on grant.
REQ-020 out and sel retain their last values in IDLE; only out_valid and gnt clear.

Reset
REQ-021 When rst=1 at a clock edge: state=IDLE, out_valid=0, gnt=0, sel=0, out=0, ptr=3; the first search therefore begins at A.
REQ-022 Reset asserted during HOLD drops the pending transfer without a handshake, and rst overrides all other inputs that cycle.
REQ-023 First grant is possible on the edge after rst deasserts.

Configuration
REQ-024 With macro WAY4_ARB_CNT_EN defined, the block adds output port grant_cnt  output  8. This port counts completed handshakes, saturates at 255, and resets to 0.
REQ-025 Without WAY4_ARB_CNT_EN, grant_cnt and its counter are absent, and all other behaviour is identical.

Verification
REQ-026 Reset then req=4'b0001, A=8, out_ready=1: the next cycle gives out_valid=1, sel=0, gnt=0001, out=8. The cycle after, with req=0, gives out_valid=0.
REQ-027 req=4'b1111, A=8, B=6, C=4, D=2, out_ready=1 continuously from reset: sel sequence is 0,1,2,3,0 and out sequence is 8,6,4,2,8, with out_valid high every cycle.
REQ-028 Grant D (out=2), then hold out_ready=0 for 5 cycles while D changes to 31 and req changes to 0001: out=2, sel=3 and gnt=1000 stay stable. On out_ready=1 the next grant is A.
REQ-029 Assert rst during HOLD with out_valid=1: the next cycle gives out_valid=0, gnt=0, out=0, sel=0. Then req=1111 grants A first.
REQ-030 With WAY4_ARB_CNT_EN, run 300 back-to-back handshakes: grant_cnt reaches 255 and stays there, and rst returns it to 0.
